// File: rtl/qbert_only_keys_pio_if.sv
// Avalon-MM slave bus bundle for the Qbert key/switch input PIO.
interface qbert_only_keys_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/qbert_only_keys_pio.sv
// Avalon-MM input PIO: two-flop sync, edge capture (W1C), maskable level IRQ.
// Optional per-bit debounce is built when QBERT_KEYS_DEBOUNCE_EN is defined.
module qbert_only_keys_pio #(
  parameter int               WIDTH           = 4,
  parameter int               EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] IDLE_LEVEL      = {WIDTH{1'b1}},
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               CNT_W           = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  qbert_only_keys_pio_if.slave bus,
  input  logic [WIDTH-1:0]     in_port,
  output logic                 irq
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_edgecap;
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] w_level;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr;
  logic             w_unused;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= IDLE_LEVEL;
      r_s2 <= IDLE_LEVEL;
    end else begin
      r_s1 <= in_port;
      r_s2 <= r_s1;
    end
  end

`ifdef QBERT_KEYS_DEBOUNCE_EN
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_db
      logic [CNT_W-1:0] r_cnt;
      logic             r_level;

      // A level change is accepted only after DEBOUNCE_CYCLES consecutive mismatches.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_cnt   <= '0;
          r_level <= IDLE_LEVEL[gi];
        end else if (r_s2[gi] == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          r_level <= r_s2[gi];
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      assign w_level[gi] = r_level;
    end
  endgenerate
  assign w_unused = &{1'b0, bus.writedata};
`else
  assign w_level  = r_s2;
  assign w_unused = &{1'b0, bus.writedata, DEBOUNCE_CYCLES[0], CNT_W[0]};
`endif

  always_comb begin
    w_rise = w_level & ~r_prev;
    w_fall = ~w_level & r_prev;
    case (EDGE_TYPE)
      0:       w_edge = w_rise;
      1:       w_edge = w_fall;
      default: w_edge = w_rise | w_fall;
    endcase
  end

  assign w_wr  = bus.chipselect && !bus.write_n;
  assign w_clr = (w_wr && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev    <= IDLE_LEVEL;
      r_edgecap <= '0;
      r_irqmask <= '0;
    end else begin
      r_prev    <= w_level;
      // New edges win over a simultaneous write-1-to-clear.
      r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
      if (w_wr && bus.address == 2'd2) begin
        r_irqmask <= bus.writedata[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      2'd0:    bus.readdata[WIDTH-1:0] = w_level;
      2'd2:    bus.readdata[WIDTH-1:0] = r_irqmask;
      2'd3:    bus.readdata[WIDTH-1:0] = r_edgecap;
      default: bus.readdata = '0;
    endcase
  end

  assign irq = |(r_edgecap & r_irqmask);

endmodule
